// File: rtl/dcache_line_writeback_pkg.sv
// dcache_line_writeback_pkg
// Shared constants and FSM state encoding for the dcache write-back serializer.
// Optional feature macro used by the block: DCACHE_WB_BYTE_MASK_EN.
package dcache_line_writeback_pkg;

   localparam int LINE_BITS        = 256;
   localparam int WORD_BITS        = 32;
   localparam int WORD_OFFSET_BITS = 3;

   // AXI write-address constants for a full-line INCR burst of 32-bit beats.
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_4B    = 3'b010;
   localparam logic [7:0] WB_AWLEN   = 8'd7;

   // Clears the byte-within-line offset so the burst starts on the line boundary.
   localparam logic [31:0] LINE_ADDR_MASK = 32'hFFFF_FFE0;

   // Write-back FSM states, kept as plain constants for legacy tooling.
   typedef logic [1:0] wb_state_t;
   localparam wb_state_t ST_IDLE = 2'd0;
   localparam wb_state_t ST_ADDR = 2'd1;
   localparam wb_state_t ST_DATA = 2'd2;
   localparam wb_state_t ST_RESP = 2'd3;

endpackage

// File: rtl/dcache_line_writeback_line_beat_shifter.sv
// line_beat_shifter
// Holds the evicted line (and, with DCACHE_WB_BYTE_MASK_EN, its byte-dirty
// mask) and shifts it down one word per accepted W beat, so the current beat
// is always word 0. The buffer is intentionally not reset: it is always
// reloaded before it is presented on the bus.
module line_beat_shifter
   import dcache_line_writeback_pkg::*;
(
   input  logic                 clk,
   input  logic                 load,
   input  logic                 shift,
   input  logic [LINE_BITS-1:0] line_in,
`ifdef DCACHE_WB_BYTE_MASK_EN
   input  logic [LINE_BITS/8-1:0] mask_in,
   output logic [3:0]             strb,
`endif
   output logic [WORD_BITS-1:0] word0
);

   logic [LINE_BITS-1:0] line_buf_r;

   // Line buffer: capture on accept, drop the sent word on each W handshake.
   always_ff @(posedge clk) begin
      if (load) begin
         line_buf_r <= line_in;
      end else if (shift) begin
         line_buf_r <= {{WORD_BITS{1'b0}}, line_buf_r[LINE_BITS-1:WORD_BITS]};
      end else begin
         line_buf_r <= line_buf_r;
      end
   end

   assign word0 = line_buf_r[WORD_BITS-1:0];

`ifdef DCACHE_WB_BYTE_MASK_EN
   logic [LINE_BITS/8-1:0] mask_buf_r;

   // Byte-dirty mask buffer: moves in lockstep with the line, one nibble per beat.
   always_ff @(posedge clk) begin
      if (load) begin
         mask_buf_r <= mask_in;
      end else if (shift) begin
         mask_buf_r <= {4'h0, mask_buf_r[LINE_BITS/8-1:4]};
      end else begin
         mask_buf_r <= mask_buf_r;
      end
   end

   assign strb = mask_buf_r[3:0];
`endif

endmodule

// File: rtl/dcache_line_writeback.sv
// dcache_line_writeback
// Serializes one evicted dirty 256-bit line into a single AXI INCR write
// burst of eight 32-bit beats and reports the B response to the controller.
// Exactly one burst is in flight at a time.
// Optional macro DCACHE_WB_BYTE_MASK_EN adds the wb_mask input and drives
// wstrb from the per-byte dirty mask; otherwise wstrb is all ones.
module dcache_line_writeback
   import dcache_line_writeback_pkg::*;
#(
   parameter int         LINE_WORDS = 8,
   parameter logic [3:0] AXI_ID     = 4'd1
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 wb_req,
   output logic                 wb_ready,
   input  logic [31:0]          wb_addr,
   input  logic [LINE_BITS-1:0] wb_line,
`ifdef DCACHE_WB_BYTE_MASK_EN
   input  logic [31:0]          wb_mask,
`endif
   output logic                 wb_done,
   output logic                 wb_err,
   output logic [3:0]           awid,
   output logic [31:0]          awaddr,
   output logic [7:0]           awlen,
   output logic [2:0]           awsize,
   output logic [1:0]           awburst,
   output logic                 awvalid,
   input  logic                 awready,
   output logic [31:0]          wdata,
   output logic [3:0]           wstrb,
   output logic                 wlast,
   output logic                 wvalid,
   input  logic                 wready,
   input  logic [1:0]           bresp,
   input  logic                 bvalid,
   output logic                 bready
);

   localparam logic [WORD_OFFSET_BITS-1:0] LAST_BEAT = WORD_OFFSET_BITS'(LINE_WORDS - 1);
   localparam logic [WORD_OFFSET_BITS-1:0] ONE_BEAT  = WORD_OFFSET_BITS'(1);
   localparam logic [WORD_OFFSET_BITS-1:0] ZERO_BEAT = WORD_OFFSET_BITS'(0);

   wb_state_t                   state_r;
   logic [WORD_OFFSET_BITS-1:0] cnt_r;
   logic [31:0]                 awaddr_r;
   logic                        awvalid_r;
   logic                        wvalid_r;
   logic                        wlast_r;
   logic                        bready_r;
   logic                        wb_ready_r;
   logic                        wb_done_r;
   logic                        wb_err_r;
   logic                        load_s;
   logic                        shift_s;
   logic                        bresp_unused_s;

   // Only SLVERR/DECERR matter to the controller; bresp[0] is not needed.
   assign bresp_unused_s = bresp[0];

   // wb_ready is high only in IDLE, so wb_req alone qualifies the accept there.
   assign load_s  = (state_r == ST_IDLE) && wb_req;
   assign shift_s = wvalid_r && wready;

   line_beat_shifter u_shifter (
      .clk     (clk),
      .load    (load_s),
      .shift   (shift_s),
      .line_in (wb_line),
`ifdef DCACHE_WB_BYTE_MASK_EN
      .mask_in (wb_mask),
      .strb    (wstrb),
`endif
      .word0   (wdata)
   );

`ifndef DCACHE_WB_BYTE_MASK_EN
   assign wstrb = 4'hF;
`endif

   // Address buffer: line-aligned address captured on accept, held for the whole burst.
   always_ff @(posedge clk) begin
      if (load_s) begin
         awaddr_r <= wb_addr & LINE_ADDR_MASK;
      end else begin
         awaddr_r <= awaddr_r;
      end
   end

   // Control FSM: AW handshake, eight W beats, then B; all handshake outputs come from flops.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r    <= ST_IDLE;
         cnt_r      <= ZERO_BEAT;
         awvalid_r  <= 1'b0;
         wvalid_r   <= 1'b0;
         wlast_r    <= 1'b0;
         bready_r   <= 1'b0;
         wb_ready_r <= 1'b1;
         wb_done_r  <= 1'b0;
         wb_err_r   <= 1'b0;
      end else begin
         wb_done_r <= 1'b0;
         wb_err_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (wb_req) begin
                  state_r    <= ST_ADDR;
                  cnt_r      <= ZERO_BEAT;
                  awvalid_r  <= 1'b1;
                  wb_ready_r <= 1'b0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ADDR: begin
               if (awready) begin
                  state_r   <= ST_DATA;
                  awvalid_r <= 1'b0;
                  wvalid_r  <= 1'b1;
                  wlast_r   <= (cnt_r == LAST_BEAT);
               end else begin
                  state_r <= ST_ADDR;
               end
            end
            ST_DATA: begin
               if (wready) begin
                  cnt_r <= cnt_r + ONE_BEAT;
                  if (cnt_r == LAST_BEAT) begin
                     state_r  <= ST_RESP;
                     wvalid_r <= 1'b0;
                     wlast_r  <= 1'b0;
                     bready_r <= 1'b1;
                  end else begin
                     wlast_r <= ((cnt_r + ONE_BEAT) == LAST_BEAT);
                  end
               end else begin
                  state_r <= ST_DATA;
               end
            end
            ST_RESP: begin
               if (bvalid) begin
                  state_r    <= ST_IDLE;
                  bready_r   <= 1'b0;
                  wb_done_r  <= 1'b1;
                  wb_err_r   <= bresp[1];
                  wb_ready_r <= 1'b1;
               end else begin
                  state_r <= ST_RESP;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               cnt_r      <= ZERO_BEAT;
               awvalid_r  <= 1'b0;
               wvalid_r   <= 1'b0;
               wlast_r    <= 1'b0;
               bready_r   <= 1'b0;
               wb_ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign wb_ready = wb_ready_r;
   assign wb_done  = wb_done_r;
   assign wb_err   = wb_err_r;
   assign awid     = AXI_ID;
   assign awaddr   = awaddr_r;
   assign awlen    = WB_AWLEN;
   assign awsize   = SIZE_4B;
   assign awburst  = BURST_INCR;
   assign awvalid  = awvalid_r;
   assign wlast    = wlast_r;
   assign wvalid   = wvalid_r;
   assign bready   = bready_r;

endmodule

// File: tb/tb_dcache_line_writeback.sv
// tb_dcache_line_writeback
// Directed bench for the write-back serializer. Expected beats are pushed to a
// scoreboard queue when a request is driven and popped on each W handshake.
// Inputs are driven and outputs sampled on the falling clock edge.
// Honours DCACHE_WB_BYTE_MASK_EN for the wb_mask port and strobe expectations.
module tb_dcache_line_writeback;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } beat_t;

   logic         clk = 1'b0;
   logic         resetn;
   logic         wb_req;
   logic         wb_ready;
   logic [31:0]  wb_addr;
   logic [255:0] wb_line;
   logic [31:0]  wb_mask;
   logic         wb_done;
   logic         wb_err;
   logic [3:0]   awid;
   logic [31:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic [1:0]   awburst;
   logic         awvalid;
   logic         awready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wlast;
   logic         wvalid;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;

   beat_t        exp_q[$];
   int           vectors     = 0;
   int           miscompares = 0;
   int           beats       = 0;
   logic         prev_w_stall  = 1'b0;
   logic         prev_aw_stall = 1'b0;
   logic [31:0]  prev_wdata    = 32'h0;
   logic         prev_wlast    = 1'b0;
   logic [31:0]  prev_awaddr   = 32'h0;
   logic [255:0] line_v;

   dcache_line_writeback dut (
      .clk      (clk),
      .resetn   (resetn),
      .wb_req   (wb_req),
      .wb_ready (wb_ready),
      .wb_addr  (wb_addr),
      .wb_line  (wb_line),
`ifdef DCACHE_WB_BYTE_MASK_EN
      .wb_mask  (wb_mask),
`endif
      .wb_done  (wb_done),
      .wb_err   (wb_err),
      .awid     (awid),
      .awaddr   (awaddr),
      .awlen    (awlen),
      .awsize   (awsize),
      .awburst  (awburst),
      .awvalid  (awvalid),
      .awready  (awready),
      .wdata    (wdata),
      .wstrb    (wstrb),
      .wlast    (wlast),
      .wvalid   (wvalid),
      .wready   (wready),
      .bresp    (bresp),
      .bvalid   (bvalid),
      .bready   (bready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Per-cycle protocol monitor; inputs for the coming edge are already driven.
   task automatic mon();
      beat_t b;
      if (prev_aw_stall) begin
         chk("aw_hold_valid", awvalid, 1'b1);
         chk("aw_hold_addr", awaddr, prev_awaddr);
      end
      if (awvalid) chk("no_w_before_aw", wvalid, 1'b0);
      if (prev_w_stall) begin
         chk("w_hold_valid", wvalid, 1'b1);
         chk("w_hold_data", wdata, prev_wdata);
         chk("w_hold_last", wlast, prev_wlast);
      end
      if (wvalid && wready) begin
         chk("beat_expected", (exp_q.size() > 0), 1'b1);
         if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            chk("wdata", wdata, b.data);
            chk("wlast", wlast, b.last);
            chk("wstrb", wstrb, b.strb);
         end
         beats++;
      end
      prev_w_stall  = wvalid && !wready;
      prev_wdata    = wdata;
      prev_wlast    = wlast;
      prev_aw_stall = awvalid && !awready;
      prev_awaddr   = awaddr;
   endtask

   // One write-back: drive the request, shape the readies, check the whole burst.
   task automatic run_txn(input logic [31:0] addr, input logic [255:0] line,
                          input logic [31:0] mask, input int aw_stall,
                          input logic [3:0] wpat, input int b_delay,
                          input logic [1:0] resp, input int exp_lat,
                          input int abort_beats);
      beat_t b;
      int aw_cnt = 0;
      int w_idx  = 0;
      int b_cnt  = 0;
      int aw_k   = -1;
      int done_k = -1;
      bit aborted = 1'b0;
      @(negedge clk);
      chk("ready_before_req", wb_ready, 1'b1);
      wb_req  = 1'b1;
      wb_addr = addr;
      wb_line = line;
      wb_mask = mask;
      bvalid  = 1'b0;
      bresp   = resp;
      awready = (aw_stall == 0);
      wready  = wpat[0];
      beats   = 0;
      for (int i = 0; i < 8; i++) begin
         b.data = line[32*i +: 32];
`ifdef DCACHE_WB_BYTE_MASK_EN
         b.strb = mask[4*i +: 4];
`else
         b.strb = 4'hF;
`endif
         b.last = (i == 7);
         exp_q.push_back(b);
      end
      mon();
      for (int k = 1; k <= 150; k++) begin
         @(negedge clk);
         wb_req = 1'b0;
         if (k == 1) begin
            chk("accept_ready_low", wb_ready, 1'b0);
            chk("accept_awvalid", awvalid, 1'b1);
         end
         if (abort_beats > 0 && beats == abort_beats) begin
            resetn  = 1'b0;
            wready  = 1'b0;
            aborted = 1'b1;
            break;
         end
         awready = (aw_cnt >= aw_stall);
         if (awvalid) aw_cnt++;
         wready = wpat[w_idx % 4];
         if (wvalid) w_idx++;
         if (bready) begin
            bvalid = (b_cnt >= b_delay);
            b_cnt++;
         end else begin
            bvalid = 1'b0;
         end
         if (aw_k >= 0 && k == aw_k + 1) chk("w_after_aw", wvalid, 1'b1);
         if (awvalid && awready) begin
            aw_k = k;
            chk("awaddr", awaddr, addr & 32'hFFFF_FFE0);
            chk("awlen", awlen, 8'd7);
            chk("awsize", awsize, 3'b010);
            chk("awburst", awburst, 2'b01);
            chk("awid", awid, 4'd1);
         end
         mon();
         if (done_k >= 0) begin
            chk("done_single_pulse", wb_done, 1'b0);
            chk("ready_after_done", wb_ready, 1'b1);
            break;
         end
         if (wb_done) begin
            done_k = k;
            if (exp_lat >= 0) chk("done_latency", k, exp_lat);
            chk("done_err", wb_err, resp[1]);
            chk("done_ready", wb_ready, 1'b1);
            chk("w_beat_count", beats, 8);
            chk("queue_drained", exp_q.size(), 0);
            chk("bready_dropped", bready, 1'b0);
         end
      end
      if (!aborted) chk("txn_completed", (done_k >= 0), 1'b1);
      bvalid = 1'b0;
   endtask

   initial begin
      resetn  = 1'b0;
      wb_req  = 1'b0;
      wb_addr = 32'h0;
      wb_line = '0;
      wb_mask = 32'h0;
      awready = 1'b0;
      wready  = 1'b0;
      bresp   = 2'b00;
      bvalid  = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state.
      chk("rst_wb_ready", wb_ready, 1'b1);
      chk("rst_awvalid", awvalid, 1'b0);
      chk("rst_wvalid", wvalid, 1'b0);
      chk("rst_bready", bready, 1'b0);
      chk("rst_wb_done", wb_done, 1'b0);
      chk("rst_wb_err", wb_err, 1'b0);
      resetn = 1'b1;

      // Basic burst, all readies high: wb_done in cycle 11 after the accept cycle.
      for (int i = 0; i < 8; i++) line_v[32*i +: 32] = 32'h1111_1111 * (i + 1);
      run_txn(32'h8000_1234, line_v, 32'hFFFF_FFFF, 0, 4'b1111, 0, 2'b00, 11, 0);

      // W backpressure with wready 1,0,0,1,... and an EXOKAY response (not an error).
      for (int i = 0; i < 8; i++) line_v[32*i +: 32] = $urandom;
      run_txn(32'h0000_0FFF, line_v, 32'hFFFF_FFFF, 0, 4'b1001, 0, 2'b01, -1, 0);

      // AW stall: awready low for 5 cycles.
      for (int i = 0; i < 8; i++) line_v[32*i +: 32] = 32'hA5A5_0000 + i;
      run_txn(32'h1234_5678, line_v, 32'hFFFF_FFFF, 5, 4'b1111, 0, 2'b00, -1, 0);

      // Error response: SLVERR with bvalid after 3 cycles.
      for (int i = 0; i < 8; i++) line_v[32*i +: 32] = ~(32'h0101_0101 * i);
      run_txn(32'hFFFF_FFE0, line_v, 32'hFFFF_FFFF, 0, 4'b1111, 3, 2'b10, -1, 0);

      // DECERR also reports an error.
      run_txn(32'h4000_0040, line_v, 32'hFFFF_FFFF, 1, 4'b1111, 1, 2'b11, -1, 0);

      // Reset mid-burst after the third beat.
      for (int i = 0; i < 8; i++) line_v[32*i +: 32] = 32'hDEAD_0000 + i;
      run_txn(32'h2000_0000, line_v, 32'hFFFF_FFFF, 0, 4'b1111, 0, 2'b00, -1, 3);
      @(negedge clk);
      chk("abort_awvalid", awvalid, 1'b0);
      chk("abort_wvalid", wvalid, 1'b0);
      chk("abort_bready", bready, 1'b0);
      chk("abort_wb_ready", wb_ready, 1'b1);
      chk("abort_wb_done", wb_done, 1'b0);
      resetn = 1'b1;
      exp_q.delete();
      prev_w_stall  = 1'b0;
      prev_aw_stall = 1'b0;
      for (int i = 0; i < 8; i++) line_v[32*i +: 32] = 32'hBEEF_0010 + i;
      run_txn(32'h2000_0020, line_v, 32'hFFFF_FFFF, 0, 4'b1111, 0, 2'b00, 11, 0);

`ifdef DCACHE_WB_BYTE_MASK_EN
      // Byte mask: strobes per beat 1, A, 0, F, 0, 0, 0, 0; all eight beats still sent.
      for (int i = 0; i < 8; i++) line_v[32*i +: 32] = 32'hC0DE_0000 + i;
      run_txn(32'h3000_0000, line_v, 32'h0000_F0A1, 0, 4'b1111, 0, 2'b00, 11, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
